// File: rtl/video_timing_generator_pkg.sv
// Shared video mode description and the canned HDMI/VGA modes used by the raster timing generator.
package video_timing_generator_pkg;

    typedef struct packed {
        logic [11:0] h_visible;
        logic [11:0] h_front;
        logic [11:0] h_sync;
        logic [11:0] h_back;
        logic [11:0] v_visible;
        logic [11:0] v_front;
        logic [11:0] v_sync;
        logic [11:0] v_back;
        logic        h_sync_pol;
        logic        v_sync_pol;
    } VideoMode;

    localparam VideoMode VIDEO_MODE_VGA = '{
        h_visible: 12'd640,  h_front: 12'd16,  h_sync: 12'd96, h_back: 12'd48,
        v_visible: 12'd480,  v_front: 12'd10,  v_sync: 12'd2,  v_back: 12'd33,
        h_sync_pol: 1'b0,    v_sync_pol: 1'b0
    };

    localparam VideoMode VIDEO_MODE_720P = '{
        h_visible: 12'd1280, h_front: 12'd110, h_sync: 12'd40, h_back: 12'd220,
        v_visible: 12'd720,  v_front: 12'd5,   v_sync: 12'd5,  v_back: 12'd20,
        h_sync_pol: 1'b1,    v_sync_pol: 1'b1
    };

    localparam VideoMode VIDEO_MODE_1080P = '{
        h_visible: 12'd1920, h_front: 12'd88,  h_sync: 12'd44, h_back: 12'd148,
        v_visible: 12'd1080, v_front: 12'd4,   v_sync: 12'd5,  v_back: 12'd36,
        h_sync_pol: 1'b1,    v_sync_pol: 1'b1
    };

    // Full period of one axis, wrapping in 12 bits like the counters that use it.
    function automatic logic [11:0] span_total(input logic [11:0] visible,
                                               input logic [11:0] front,
                                               input logic [11:0] sync,
                                               input logic [11:0] back);
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/video_timing_generator_sync_region.sv
// Decodes one raster axis (horizontal or vertical): visible area, sync pulse level and wrap point.
module sync_region
    import video_timing_generator_pkg::*;
(
    input  logic [11:0] pos,
    input  logic [11:0] visible,
    input  logic [11:0] front,
    input  logic [11:0] sync,
    input  logic [11:0] back,
    input  logic        pol,
    output logic        in_visible,
    output logic        sync_level,
    output logic        wrap
);

    logic [11:0] sync_start;
    logic [11:0] sync_end;
    logic [11:0] total;

    always_comb begin
        sync_start = visible + front;
        sync_end   = sync_start + sync;
        total      = span_total(visible, front, sync, back);
        in_visible = pos < visible;
        // Negative polarity inverts the raw pulse so the idle level is high.
        sync_level = ((pos >= sync_start) && (pos < sync_end)) ^ ~pol;
        // Anything at or past the last position wraps, so a shrinking mode can never run away.
        wrap       = pos >= (total - 12'd1);
    end

endmodule

// File: rtl/video_timing_generator.sv
// Raster timing generator: pixel/line counters, syncs, DE and strobes; mode changes land only on frame boundaries.
module video_timing_generator
    import video_timing_generator_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  VideoMode    videoMode,
    output logic [11:0] counterX,
    output logic [11:0] counterY,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        line_start,
    output logic        frame_start
);

    VideoMode    active_mode_q, active_mode_d;
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic [11:0] counter_x_q, counter_x_d;
    logic [11:0] counter_y_q, counter_y_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        de_q, de_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;

    logic        h_visible_flag, h_sync_level, h_wrap;
    logic        v_visible_flag, v_sync_level, v_wrap;

    sync_region u_h_region (
        .pos        (x_q),
        .visible    (active_mode_q.h_visible),
        .front      (active_mode_q.h_front),
        .sync       (active_mode_q.h_sync),
        .back       (active_mode_q.h_back),
        .pol        (active_mode_q.h_sync_pol),
        .in_visible (h_visible_flag),
        .sync_level (h_sync_level),
        .wrap       (h_wrap)
    );

    sync_region u_v_region (
        .pos        (y_q),
        .visible    (active_mode_q.v_visible),
        .front      (active_mode_q.v_front),
        .sync       (active_mode_q.v_sync),
        .back       (active_mode_q.v_back),
        .pol        (active_mode_q.v_sync_pol),
        .in_visible (v_visible_flag),
        .sync_level (v_sync_level),
        .wrap       (v_wrap)
    );

    always_comb begin
        active_mode_d = active_mode_q;
        x_d           = h_wrap ? 12'd0 : x_q + 12'd1;
        y_d           = y_q;
        if (h_wrap) begin
            if (v_wrap) begin
                y_d           = 12'd0;
                // Only the request present on the final pixel of a frame is taken.
                active_mode_d = videoMode;
            end else begin
                y_d = y_q + 12'd1;
            end
        end

        counter_x_d   = x_q;
        counter_y_d   = y_q;
        hsync_d       = h_sync_level;
        vsync_d       = v_sync_level;
        de_d          = h_visible_flag && v_visible_flag;
        line_start_d  = (x_q == 12'd0);
        frame_start_d = (x_q == 12'd0) && (y_q == 12'd0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active_mode_q <= VIDEO_MODE_1080P;
            x_q           <= 12'd0;
            y_q           <= 12'd0;
            counter_x_q   <= 12'd0;
            counter_y_q   <= 12'd0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            active_mode_q <= active_mode_d;
            x_q           <= x_d;
            y_q           <= y_d;
            counter_x_q   <= counter_x_d;
            counter_y_q   <= counter_y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign counterX    = counter_x_q;
    assign counterY    = counter_y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule
